// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter slice.
package uart_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StRelease
    } uart_arb_state_e;

    localparam int unsigned DefaultNReq          = 4;
    localparam int unsigned DefaultTimeoutCycles = 65535;
    // Wide enough for up to 8 requesters.
    localparam int unsigned GrantIdxW            = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: finds the first set request at or after last_grant+1, with wrap.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NReq = DefaultNReq
) (
    input  logic [NReq-1:0]      req,
    input  logic [GrantIdxW-1:0] last_grant,
    output logic                 found,
    output logic [GrantIdxW-1:0] idx
);

    logic [2*NReq-1:0] req_dbl;
    logic [2*NReq-1:0] req_rot;
    int unsigned       sum;

    // Rotate so bit 0 is the requester just after last_grant, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl >> (32'(last_grant) + 32'd1);
        found   = 1'b0;
        idx     = '0;
        sum     = 0;
        for (int unsigned j = 0; j < NReq; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                sum   = 32'(last_grant) + 32'd1 + j;
                if (sum >= NReq) begin
                    sum = sum - NReq;
                end
                idx = GrantIdxW'(sum);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte senders onto one UART transmitter.
// Optional launch timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ          = DefaultNReq,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   err,
    output logic [7:0]         uart_data_in,
    output logic               uart_data_in_valid,
    input  logic               uart_busy,
    input  logic               uart_tx,
    output logic [2:0]         grant_id,
    output logic               active
);

    uart_arb_state_e      state_q, state_d;
    logic [7:0]           hold_q, hold_d;
    logic [GrantIdxW-1:0] last_grant_q, last_grant_d;
    logic [GrantIdxW-1:0] grant_id_q, grant_id_d;
    logic                 rr_found;
    logic [GrantIdxW-1:0] rr_idx;
    logic [7:0]           win_byte;
    logic                 timeout;

    rr_arbiter #(
        .NReq (N_REQ)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant_q),
        .found      (rr_found),
        .idx        (rr_idx)
    );

    // Select the winning requester's byte for the hold register.
    always_comb begin
        win_byte = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rr_idx == GrantIdxW'(i)) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    // Counter sits at zero in IDLE so it is cleared on LAUNCH entry; counts LAUNCH cycles.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == StIdle) begin
            tmo_d = '0;
        end else if (state_q == StLaunch) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout = (state_q == StLaunch) && (tmo_q == 16'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic; the hold register only loads on grant so data_in stays stable.
    always_comb begin
        state_d            = state_q;
        hold_d             = hold_q;
        last_grant_d       = last_grant_q;
        grant_id_d         = grant_id_q;
        uart_data_in_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rr_found && !uart_busy) begin
                    hold_d     = win_byte;
                    grant_id_d = rr_idx;
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                if (timeout) begin
                    last_grant_d = grant_id_q;
                    state_d      = StIdle;
                end else begin
                    // Held through any UART receive activity until the start bit shows.
                    uart_data_in_valid = 1'b1;
                    if (!uart_tx) begin
                        state_d = StWaitDone;
                    end
                end
            end
            StWaitDone: begin
                if (!uart_busy) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                last_grant_d = grant_id_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, hold and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            last_grant_q <= GrantIdxW'(N_REQ - 1);
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    // One-hot completion pulses decoded from the registered state.
    always_comb begin
        ack = '0;
        err = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ack[i] = (state_q == StRelease) && (grant_id_q == GrantIdxW'(i));
            err[i] = timeout && (grant_id_q == GrantIdxW'(i));
        end
    end

    assign uart_data_in = hold_q;
    assign grant_id     = grant_id_q;
    assign active       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small bit-serial UART model.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned Tmo = 100;
`else
    localparam int unsigned Tmo = 65535;
`endif
    localparam int BitClks = 8;
    localparam int RxClks  = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [7:0]  uart_data_in;
    logic        uart_data_in_valid;
    logic        uart_busy;
    logic        uart_tx;
    logic [2:0]  grant_id;
    logic        active;

    int          checks   = 0;
    int          failures = 0;
    int          viol     = 0;
    int          ack_total = 0;
    int          err_total = 0;
    int          rx_cmd   = 0;
    int          rx_seen  = 0;
    logic        stuck    = 1'b0;
    logic [7:0]  last_sent = 8'h00;
    logic [7:0]  shreg;

    uart_tx_arbiter #(
        .N_REQ          (4),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .req_data           (req_data),
        .ack                (ack),
        .err                (err),
        .uart_data_in       (uart_data_in),
        .uart_data_in_valid (uart_data_in_valid),
        .uart_busy          (uart_busy),
        .uart_tx            (uart_tx),
        .grant_id           (grant_id),
        .active             (active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input string tag, output int id, output logic [2:0] gid);
        bit ok;
        ok  = 1'b0;
        id  = -1;
        gid = '0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            if (|ack) begin
                ok  = 1'b1;
                gid = grant_id;
                for (int i = 0; i < 4; i++) if (ack[i]) id = i;
            end
        end
        check_eq({tag, "_ack_seen"}, 32'(ok), 32'd1);
    endtask

    // UART model: samples data_in bit by bit while shifting, or fakes a receive (busy, tx high).
    initial begin
        uart_tx   = 1'b1;
        uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rx_cmd != rx_seen) begin
                rx_seen   = rx_cmd;
                uart_busy = 1'b1;
                repeat (RxClks) @(posedge clk);
                #1;
                uart_busy = 1'b0;
            end else if (uart_data_in_valid && !stuck) begin
                uart_busy = 1'b1;
                uart_tx   = 1'b0;
                repeat (BitClks) @(posedge clk);
                for (int b = 0; b < 8; b++) begin
                    #1;
                    uart_tx  = uart_data_in[b];
                    shreg[b] = uart_data_in[b];
                    repeat (BitClks) @(posedge clk);
                end
                #1;
                uart_tx = 1'b1;
                repeat (BitClks) @(posedge clk);
                #1;
                uart_busy = 1'b0;
                last_sent = shreg;
            end
        end
    end

    // Track pulse counts and any cycle with more than one ack/err bit high.
    always @(negedge clk) begin
        if ($countones({ack, err}) > 1) viol <= viol + 1;
        if (|ack) ack_total <= ack_total + 1;
        if (|err) err_total <= err_total + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          id;
        logic [2:0]  gid;
        bit          seen;
        int          exp_id[5];
        logic [7:0]  exp_byte[5];
        int          n;

        exp_id   = '{0, 1, 2, 3, 0};
        exp_byte = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;

        // Reset state.
        @(negedge clk);
        check_eq("rst_active", 32'(active), 32'd0);
        check_eq("rst_valid", 32'(uart_data_in_valid), 32'd0);
        check_eq("rst_data", 32'(uart_data_in), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesting continuously: 0,1,2,3,0.
        req_data = 32'h44332211;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack("rr", id, gid);
            check_eq($sformatf("rr_id%0d", k), 32'(id), 32'(exp_id[k]));
            check_eq($sformatf("rr_byte%0d", k), 32'(last_sent), 32'(exp_byte[k]));
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Single request, first-cycle LAUNCH outputs then completion.
        req_data[7:0] = 8'h55;
        req           = 4'b0001;
        @(negedge clk);
        check_eq("single_active", 32'(active), 32'd1);
        check_eq("single_valid", 32'(uart_data_in_valid), 32'd1);
        check_eq("single_hold", 32'(uart_data_in), 32'h55);
        wait_ack("single", id, gid);
        req = '0;
        check_eq("single_id", 32'(id), 32'd0);
        check_eq("single_grant_id", 32'(gid), 32'd0);
        check_eq("single_byte", 32'(last_sent), 32'h55);
        repeat (3) @(negedge clk);
        check_eq("single_idle", 32'(active), 32'd0);

        // Requester byte changes mid-frame; held copy must go out.
        req_data[7:0] = 8'hA5;
        req           = 4'b0001;
        repeat (30) @(negedge clk);
        req_data[7:0] = 8'h00;
        wait_ack("hold", id, gid);
        req = '0;
        check_eq("hold_byte", 32'(last_sent), 32'hA5);
        repeat (3) @(negedge clk);

        // UART busy receiving when req[2] rises: no grant until busy clears.
        rx_cmd = rx_cmd + 1;
        repeat (2) @(negedge clk);
        req_data[23:16] = 8'h3C;
        req             = 4'b0100;
        repeat (5) @(negedge clk);
        check_eq("busy_nogrant_a", 32'(active), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("busy_nogrant_b", 32'(active), 32'd0);
        wait_ack("busy", id, gid);
        req = '0;
        check_eq("busy_id", 32'(id), 32'd2);
        check_eq("busy_byte", 32'(last_sent), 32'h3C);
        repeat (3) @(negedge clk);

        // Reset during WAIT_DONE aborts silently; then req[0] wins first.
        req_data[7:0]   = 8'h5A;
        req_data[31:24] = 8'hC3;
        req             = 4'b1000;
        seen            = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (active && !uart_data_in_valid) seen = 1'b1;
        end
        check_eq("wd_reached", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("wd_rst_active", 32'(active), 32'd0);
        check_eq("wd_rst_valid", 32'(uart_data_in_valid), 32'd0);
        check_eq("wd_rst_data", 32'(uart_data_in), 32'd0);
        check_eq("wd_rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("wd_rst_ack", 32'(ack), 32'd0);
        req = 4'b1001;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_ack("after_rst", id, gid);
        req = '0;
        check_eq("after_rst_id", 32'(id), 32'd0);
        check_eq("after_rst_byte", 32'(last_sent), 32'h5A);
        repeat (3) @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
        // Start bit never appears: err after exactly Tmo LAUNCH cycles.
        stuck         = 1'b1;
        req_data[7:0] = 8'h99;
        req           = 4'b0001;
        seen          = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (uart_data_in_valid) seen = 1'b1;
        end
        check_eq("tmo_launch", 32'(seen), 32'd1);
        n = 0;
        while (n < 300 && !(|err)) begin
            @(negedge clk);
            n++;
        end
        req = '0;
        check_eq("tmo_cycles", 32'(n), 32'(Tmo));
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_valid", 32'(uart_data_in_valid), 32'd0);
        @(negedge clk);
        check_eq("tmo_idle", 32'(active), 32'd0);
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("err_total", 32'(err_total), 32'd1);
`else
        n = 0;
        check_eq("err_total", 32'(err_total), 32'd0);
`endif

        check_eq("ack_total", 32'(ack_total), 32'd9);
        check_eq("onehot", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum LAUNCH dwell in clk cycles (16-bit).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  N_REQ  per-requester send request; level, held until ack or err.
REQ-006 SHALL have port req_data  input  8*N_REQ  byte of requester i at bits [8i+7:8i].
REQ-007 SHALL have port ack  output  N_REQ  one-cycle pulse: requester's byte fully sent.
REQ-008 SHALL have port err  output  N_REQ  one-cycle pulse: requester's byte dropped on timeout (REQ-030 only).
REQ-009 SHALL have port uart_data_in  output  8  byte driven to the UART data_in.
REQ-010 SHALL have port uart_data_in_valid  output  1  send strobe to the UART data_in_valid.
REQ-011 SHALL have port uart_busy  input  1  UART busy output.
REQ-012 SHALL have port uart_tx  input  1  UART serial tx line, monitored for the start bit.
REQ-013 SHALL have port grant_id  output  3  index of the current or last granted requester.
REQ-014 SHALL have port active  output  1  high while state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, WAIT_DONE, RELEASE.
REQ-016 IDLE: when any req bit is high and uart_busy=0, SHALL grant by round-robin, latch req_data of the winner into a hold register, set grant_id, and go to LAUNCH next cycle.
REQ-017 Round-robin SHALL search from index (last_grant+1) mod N_REQ upward with wrap; after reset the search SHALL start at index 0.
REQ-018 uart_data_in SHALL equal the hold register and SHALL stay constant from LAUNCH entry to RELEASE exit, because the UART samples data_in bit-by-bit during transmission.
REQ-019 LAUNCH: uart_data_in_valid SHALL be 1; on uart_tx=0 (start bit seen), go to WAIT_DONE.
REQ-020 If the UART is receiving (busy high, tx high), LAUNCH SHALL hold valid until the start bit appears.
REQ-021 WAIT_DONE: uart_data_in_valid SHALL be 0; on uart_busy=0, go to RELEASE.
REQ-022 RELEASE: ack[grant_id] SHALL pulse for exactly one cycle, last_grant SHALL update, and the state SHALL return to IDLE next cycle.
REQ-023 A req edge during LAUNCH, WAIT_DONE or RELEASE SHALL only be evaluated at the next IDLE.
REQ-024 Deassertion of the granted req after grant SHALL NOT abort the transfer; ack still pulses.
REQ-025 At most one ack or err bit SHALL be high in any cycle.
REQ-026 Minimum grant-to-grant spacing SHALL be one IDLE cycle.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously set state=IDLE, hold register=0, last_grant=N_REQ-1, grant_id=0, and timeout counter=0.
REQ-028 During reset the outputs SHALL be ack=0, err=0, uart_data_in_valid=0, uart_data_in=0, active=0.
REQ-029 Reset asserted mid-transfer SHALL abort with no ack or err pulse.

Configuration
REQ-030 With macro UART_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on LAUNCH entry and increment each LAUNCH cycle; on reaching TIMEOUT_CYCLES it SHALL pulse err[grant_id], update last_grant, and return to IDLE with valid=0.
REQ-031 Without UART_ARB_TIMEOUT_EN, no counter SHALL be built, err SHALL be tied to 0, and LAUNCH SHALL wait indefinitely.

Structure
REQ-032 Shared package uart_pkg SHALL hold the state enum, the default N_REQ, the default TIMEOUT_CYCLES, and the grant-index width.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last_grant; outputs a found flag and an index).
REQ-034 The hold register, FSM and timeout counter SHALL stay in uart_tx_arbiter.

Verification
REQ-035 Single request: req=4'b0001, byte 0x55, with a 9600-baud UART model -> serial frame 0x55, then ack[0] pulses once and grant_id=0.
REQ-036 All four requesting continuously -> grants in order 0,1,2,3,0; each byte appears intact on uart_tx.
REQ-037 Change req_data[7:0] from 0xA5 to 0x00 mid-frame -> transmitted byte remains 0xA5.
REQ-038 Inject an rx frame so uart_busy is high when req[2] rises -> no grant until busy=0; byte sent afterwards; ack[2] pulses.
REQ-039 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, tx held high -> err pulses exactly 100 cycles after LAUNCH entry; state returns to IDLE.
REQ-040 Pull rst_n low during WAIT_DONE -> outputs reset immediately, no ack; after release, req[0] is granted first.
